demux2_stream: RTL

//   Demultiplexer end of the two-way select path: one valid/ready input stream is

---
 rtl/demux2_stream_pkg.sv | 7 +
 rtl/demux2_stream_fifo_buf.sv | 51 +++++
 rtl/demux2_stream.sv | 63 ++++++
 3 files changed

// File: rtl/demux2_stream_pkg.sv
// Shared constants for the two-way stream demultiplexer and its per-channel FIFOs.
package demux2_stream_pkg;

    localparam int DEF_MSB = 31;
    localparam int DEF_LSB = 0;

endpackage : demux2_stream_pkg

// File: rtl/demux2_stream_fifo_buf.sv
// Synchronous FIFO with wrap-bit pointers; the head is forced to zero while empty.
module fifo_buf
    import demux2_stream_pkg::*;
#(
    parameter int MSB   = DEF_MSB,
    parameter int LSB   = DEF_LSB,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [MSB:LSB]             data_in,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [MSB:LSB]             head
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [MSB:LSB] r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic           w_push;
    logic           w_pop;

    assign full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign empty = (r_wptr == r_rptr);
    assign count = r_wptr - r_rptr;
    assign head  = empty ? '0 : r_mem[r_rptr[PW-2:0]];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-2:0]] <= data_in;
    end

endmodule : fifo_buf

// File: rtl/demux2_stream.sv
// Routes one valid/ready stream to one of two buffered output channels by a per-beat select.
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int MSB   = DEF_MSB,
    parameter int LSB   = DEF_LSB,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sel,
    input  logic [MSB:LSB]         in_data,
    output logic                   y0_valid,
    input  logic                   y0_ready,
    output logic [MSB:LSB]         y0,
    output logic                   y1_valid,
    input  logic                   y1_ready,
    output logic [MSB:LSB]         y1,
    output logic [$clog2(DEPTH):0] cnt0,
    output logic [$clog2(DEPTH):0] cnt1
);

    logic w_full0, w_full1;
    logic w_empty0, w_empty1;
    logic w_push0, w_push1;
    logic w_accept;

    // Readiness depends only on the registered full flag of the selected channel.
    assign in_ready = in_sel ? ~w_full1 : ~w_full0;
    assign w_accept = in_valid & in_ready;
    assign w_push0  = w_accept & ~in_sel;
    assign w_push1  = w_accept &  in_sel;

    assign y0_valid = ~w_empty0;
    assign y1_valid = ~w_empty1;

    fifo_buf #(.MSB(MSB), .LSB(LSB), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rstn    (rstn),
        .push    (w_push0),
        .pop     (y0_ready),
        .data_in (in_data),
        .full    (w_full0),
        .empty   (w_empty0),
        .count   (cnt0),
        .head    (y0)
    );

    fifo_buf #(.MSB(MSB), .LSB(LSB), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rstn    (rstn),
        .push    (w_push1),
        .pop     (y1_ready),
        .data_in (in_data),
        .full    (w_full1),
        .empty   (w_empty1),
        .count   (cnt1),
        .head    (y1)
    );

endmodule : demux2_stream
